pdm_capture: RTL

Front-end capture stage for the record path. It generates the PDM microphone clock and samples the microphone data line while recording is enabled by the controller. It packs the sampled bits into fixed-width words and hands each word, with its clip-relative address, to the memory write path over a valid/ready handshake. After a fixed number of words it reports completion back to the controller.

---
 rtl/pdm_capture.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pdm_capture.sv
// pdm_capture: generates the PDM microphone clock, samples the mic data line,
// packs bits MSB-first into words and offers each word with its clip address
// on a valid/ready port. Reports completion after SAMPLE_WORDS words.
//
// Handshake: word_valid_o/word_o/word_addr_o are held stable until a cycle with
// word_valid_o & word_ready_i (the transfer cycle). A word that completes while
// the previous one is still pending and not being taken overwrites it and sets
// the sticky overrun_o flag.
module pdm_capture #(
    parameter int CLOCK_DIVIDE = 50,
    parameter int WORD_WIDTH   = 16,
    parameter int SAMPLE_WORDS = 65535
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  mic_data_i,
    output logic                  mic_clk_o,
    output logic                  mic_lrsel_o,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic [15:0]           word_addr_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic                  overrun_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    localparam int DIV_W = $clog2(CLOCK_DIVIDE);
    localparam int BIT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [15:0]      WORD_LAST = 16'(SAMPLE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state;
    logic                  sync_1;
    logic                  sync_2;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [15:0]           word_cnt;
    logic [WORD_WIDTH-2:0] shift_reg;

    logic                  div_wrap;
    logic                  sample_evt;
    logic                  word_full;
    logic                  accept;
    logic [WORD_WIDTH-1:0] next_word;

    // Divider terminal count only matters while capturing; the falling edge
    // of mic_clk_o (toggle while high) is the sample point.
    assign div_wrap    = (state == CAPTURE) && (div_cnt == DIV_LAST);
    assign sample_evt  = div_wrap && mic_clk_o;
    assign word_full   = sample_evt && (bit_cnt == BIT_LAST);
    assign accept      = word_valid_o && word_ready_i;
    assign next_word   = {shift_reg, sync_2};
    assign mic_lrsel_o = 1'b0;
    assign state_o     = state;

    // Two-flop synchronizer for the asynchronous microphone data line.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= mic_data_i;
            sync_2 <= sync_1;
        end
    end

    // Capture FSM: clock divider, bit packing, word handshake and completion.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state        <= IDLE;
            mic_clk_o    <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            shift_reg    <= '0;
            word_o       <= '0;
            word_addr_o  <= '0;
            word_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mic_clk_o    <= 1'b0;
                    bit_cnt      <= '0;
                    word_cnt     <= '0;
                    shift_reg    <= '0;
                    word_valid_o <= 1'b0;
                    done_o       <= 1'b0;
                    if (enable_i) begin
                        // The enabling edge counts as divider step 0, so the
                        // first mic_clk_o rise lands CLOCK_DIVIDE cycles later.
                        state     <= CAPTURE;
                        div_cnt   <= DIV_ONE;
                        overrun_o <= 1'b0;
                    end else begin
                        div_cnt <= '0;
                    end
                end

                CAPTURE: begin
                    if (!enable_i) begin
                        // Abort: drop the partial word and any pending word.
                        state        <= IDLE;
                        mic_clk_o    <= 1'b0;
                        div_cnt      <= '0;
                        bit_cnt      <= '0;
                        word_cnt     <= '0;
                        word_valid_o <= 1'b0;
                    end else begin
                        if (div_wrap) begin
                            div_cnt   <= '0;
                            mic_clk_o <= ~mic_clk_o;
                        end else begin
                            div_cnt <= div_cnt + DIV_ONE;
                        end

                        if (sample_evt) begin
                            shift_reg <= next_word[WORD_WIDTH-2:0];
                            bit_cnt   <= word_full ? '0 : bit_cnt + BIT_W'(1);
                        end

                        if (word_full) begin
                            word_o       <= next_word;
                            word_addr_o  <= word_cnt;
                            word_valid_o <= 1'b1;
                            word_cnt     <= word_cnt + 16'd1;
                            if (word_valid_o && !word_ready_i) begin
                                overrun_o <= 1'b1;
                            end
                            if (word_cnt == WORD_LAST) begin
                                state     <= DONE;
                                done_o    <= 1'b1;
                                mic_clk_o <= 1'b0;
                            end
                        end else if (accept) begin
                            word_valid_o <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    mic_clk_o <= 1'b0;
                    div_cnt   <= '0;
                    if (!enable_i) begin
                        state        <= IDLE;
                        done_o       <= 1'b0;
                        word_valid_o <= 1'b0;
                    end else if (accept) begin
                        word_valid_o <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
